// File: rtl/sha256_block_sequencer.sv
// sha256_block_sequencer: iterative SHA-256 compression controller.
// Accepts padded 512-bit blocks, runs 64 rounds at UNROLL rounds per clock,
// chains H across the blocks of a message and presents the final digest.
// Optional feature macro: SHA256_ABORT_EN (adds the abort input).
module sha256_block_sequencer #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_last,
  output logic         dig_valid,
  input  logic         dig_ready,
  output logic [255:0] digest,
`ifdef SHA256_ABORT_EN
  input  logic         abort,
`endif
  output logic         busy
);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
    $error("sha256_block_sequencer: UNROLL must be 1, 2 or 4");
  end

  localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  typedef enum logic [1:0] {IDLE, ROUND, UPDATE, DONE} state_t;

  state_t         state_reg, state_next;
  logic [255:0]   h_reg;      // chained hash H0..H7, H0 in the top word
  logic [255:0]   wv_reg;     // working registers a..h, a in the top word
  logic [511:0]   win_reg;    // schedule window, top word is W_t of the current round
  logic [5:0]     t_reg;
  logic           last_reg;
  logic           abort_hit;
  logic [255:0]   h_sum;

  logic [255:0]   wv_chain  [UNROLL+1];
  logic [511:0]   win_chain [UNROLL+1];

`ifdef SHA256_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign wv_chain[0]  = wv_reg;
  assign win_chain[0] = win_reg;

  // One combinational round per stage. The window always presents W_t in its
  // top word and appends W_t+16, so the t<16 and t>=16 cases share one path.
  genvar gi;
  for (gi = 0; gi < UNROLL; gi++) begin : g_round
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] w_t, w_new, k_t, t1, t2;
    assign {a, b, c, d, e, f, g, h} = wv_chain[gi];
    assign w_t   = win_chain[gi][511:480];
    assign w_new = ssig1(win_chain[gi][63:32]) + win_chain[gi][223:192]
                 + ssig0(win_chain[gi][479:448]) + w_t;
    assign k_t   = K[t_reg + 6'(gi)];
    assign t1    = h + bsig1(e) + ((e & f) ^ (~e & g)) + k_t + w_t;
    assign t2    = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
    assign wv_chain[gi+1]  = {t1 + t2, a, b, c, d + t1, e, f, g};
    assign win_chain[gi+1] = {win_chain[gi][479:0], w_new};
  end

  for (gi = 0; gi < 8; gi++) begin : g_hsum
    assign h_sum[gi*32 +: 32] = h_reg[gi*32 +: 32] + wv_reg[gi*32 +: 32];
  end

  assign digest = h_reg;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state decode and registered-state output decode.
  always_comb begin
    state_next = state_reg;
    blk_ready  = (state_reg == IDLE) && !abort_hit;
    dig_valid  = (state_reg == DONE);
    busy       = (state_reg != IDLE);
    case (state_reg)
      IDLE:    if (blk_valid) state_next = ROUND;
      ROUND:   if (t_reg == 6'(64 - UNROLL)) state_next = UPDATE;
      UPDATE:  state_next = last_reg ? DONE : IDLE;
      DONE:    if (dig_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort_hit) state_next = IDLE;
  end

  // Datapath: block load, round iteration, H chaining and IV reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_reg    <= IV;
      wv_reg   <= '0;
      win_reg  <= '0;
      t_reg    <= '0;
      last_reg <= 1'b0;
    end else if (abort_hit) begin
      h_reg    <= IV;
      t_reg    <= '0;
      last_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (blk_valid) begin
          wv_reg   <= h_reg;
          win_reg  <= blk_data;
          last_reg <= blk_last;
          t_reg    <= '0;
        end
        ROUND: begin
          wv_reg  <= wv_chain[UNROLL];
          win_reg <= win_chain[UNROLL];
          t_reg   <= t_reg + 6'(UNROLL);
        end
        UPDATE: h_reg <= h_sum;
        DONE:   if (dig_ready) h_reg <= IV;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Directed bench for sha256_block_sequencer with a digest scoreboard.
module tb_sha256_block_sequencer;

  localparam int UNROLL = 1;
  localparam int RND    = 64 / UNROLL;

  localparam logic [255:0] IV      = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] D_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] D_TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  localparam logic [511:0] B_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] B_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] B_TWO2  = {480'h0, 32'h000001c0};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         blk_valid = 1'b0;
  logic         blk_ready;
  logic [511:0] blk_data = '0;
  logic         blk_last = 1'b0;
  logic         dig_valid;
  logic         dig_ready = 1'b1;
  logic [255:0] digest;
  logic         busy;
`ifdef SHA256_ABORT_EN
  logic         abort = 1'b0;
`endif

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [255:0] exp_q [$];

  sha256_block_sequencer #(.UNROLL(UNROLL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_last  (blk_last),
    .dig_valid (dig_valid),
    .dig_ready (dig_ready),
    .digest    (digest),
`ifdef SHA256_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every digest handshake.
  always @(negedge clk) begin
    if (rst_n && dig_valid === 1'b1 && dig_ready) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL digest_unexpected: got %h, required no digest", digest);
      end else begin
        logic [255:0] e;
        e = exp_q.pop_front();
        chk("digest", digest, e);
        $display("digest out %h (expected %h)", digest, e);
      end
    end
  end

  task automatic send_block(input logic [511:0] d, input logic last,
                            input logic [255:0] exp, input string nm);
    int n;
    @(posedge clk); #1;
    blk_valid = 1'b1;
    blk_data  = d;
    blk_last  = last;
    n = 0;
    @(negedge clk);
    while (blk_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (blk_ready !== 1'b1) begin
      compared++;
      mismatched++;
      $display("FAIL %s_accept_timeout: got blk_ready=%b, required 1", nm, blk_ready);
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    if (last) exp_q.push_back(exp);
    blk_valid = 1'b0;
    $display("block %s accepted last=%0b at cycle %0d", nm, last, acc_cyc);
  endtask

  task automatic wait_digest(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (dig_valid !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, 256'(cyc - acc_cyc), 256'(RND + 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int viol;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_blk_ready", 256'(blk_ready), 256'd1);
    chk("rst_busy",      256'(busy),      256'd0);
    chk("rst_dig_valid", 256'(dig_valid), 256'd0);
    chk("rst_digest",    digest,          IV);
    rst_n = 1'b1;

    // "abc" and empty single-block messages
    send_block(B_ABC, 1'b1, D_ABC, "abc");
    wait_digest("abc");
    send_block(B_EMPTY, 1'b1, D_EMPTY, "empty");
    wait_digest("empty");

    // Two-block message; block 2 is offered during block 1's rounds
    send_block(B_TWO1, 1'b0, '0, "two_blk1");
    blk_valid = 1'b1;
    blk_data  = B_TWO2;
    blk_last  = 1'b1;
    viol = 0;
    for (int k = 0; k < RND + 1; k++) begin
      @(negedge clk);
      if (blk_ready !== 1'b0) viol++;
    end
    chk("two_ready_low_in_rounds", 256'(viol), 256'd0);
    @(negedge clk);
    chk("two_ready_after_update", 256'(blk_ready), 256'd1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    exp_q.push_back(D_TWO);
    blk_valid = 1'b0;
    $display("block two_blk2 accepted last=1 at cycle %0d", acc_cyc);
    wait_digest("two");

    // Back-pressure: digest held 10 cycles with a block waiting
    send_block(B_ABC, 1'b1, D_ABC, "bp1");
    dig_ready = 1'b0;
    wait_digest("bp1");
    blk_valid = 1'b1;
    blk_data  = B_ABC;
    blk_last  = 1'b1;
    viol = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (digest !== D_ABC || blk_ready !== 1'b0 || dig_valid !== 1'b1) viol++;
    end
    chk("bp_hold_stable", 256'(viol), 256'd0);
    @(posedge clk); #1;
    dig_ready = 1'b1;
    send_block(B_ABC, 1'b1, D_ABC, "bp2");
    wait_digest("bp2");

    // Asynchronous reset during block 1 rounds
    send_block(B_TWO1, 1'b0, '0, "rst_blk1");
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_blk_ready", 256'(blk_ready), 256'd1);
    chk("midrst_busy",      256'(busy),      256'd0);
    chk("midrst_dig_valid", 256'(dig_valid), 256'd0);
    chk("midrst_digest",    digest,          IV);
    @(negedge clk);
    rst_n = 1'b1;
    send_block(B_ABC, 1'b1, D_ABC, "post_rst_abc");
    wait_digest("post_rst_abc");

`ifdef SHA256_ABORT_EN
    // Abort at t=30 of block 2 with a block offered on the abort cycle
    send_block(B_TWO1, 1'b0, '0, "ab_blk1");
    send_block(B_TWO2, 1'b1, D_TWO, "ab_blk2");
    repeat (30 / UNROLL) @(posedge clk);
    #1;
    abort     = 1'b1;
    blk_valid = 1'b1;
    blk_data  = B_ABC;
    blk_last  = 1'b1;
    @(negedge clk);
    chk("abort_no_ready", 256'(blk_ready), 256'd0);
    @(posedge clk); #1;
    abort     = 1'b0;
    blk_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy",      256'(busy),      256'd0);
    chk("abort_dig_valid", 256'(dig_valid), 256'd0);
    chk("abort_digest",    digest,          IV);
    void'(exp_q.pop_back());
    send_block(B_ABC, 1'b1, D_ABC, "post_abort_abc");
    wait_digest("post_abort_abc");
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 256'(exp_q.size()), 256'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
